ng_cnt_sched: RTL and testbench

Priority-counter scheduler for the clock and time-pulse generator. It accumulates increment requests for eight counter cells: the TIME1–TIME5 clock counters, driven by F10X and the TIME1 overflow, plus three external pulse sources. At each entry into TP12 it grants at most one cell to the control-pulse sequencer, which performs the counter increment in the next subsequence. It sits between the CLK1 / TPG / scaler outputs and the sequencer's counter-cycle logic.

---
 rtl/ng_cnt_sched_if.sv | 29 ++
 rtl/ng_cnt_sched.sv | 202 ++++++++++++++++++++
 tb/tb_ng_cnt_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ng_cnt_sched_if.sv
// ---------------------------------------------------------------------------
// ng_cnt_sched_if
//   Grant handshake between the priority-counter scheduler and the
//   control-pulse sequencer's counter-cycle logic.
//
//   CNT_RQ   scheduler -> sequencer  grant valid
//   CNT_SEL  scheduler -> sequencer  granted cell index, stable while CNT_RQ=1
//   CNT_ACK  sequencer -> scheduler  one-cycle acceptance of the current grant
//
//   master : scheduler side (ng_cnt_sched)
//   slave  : sequencer side
// ---------------------------------------------------------------------------
interface ng_cnt_sched_if;
  logic       CNT_RQ;
  logic [2:0] CNT_SEL;
  logic       CNT_ACK;

  modport master (
    output CNT_RQ,
    output CNT_SEL,
    input  CNT_ACK
  );

  modport slave (
    input  CNT_RQ,
    input  CNT_SEL,
    output CNT_ACK
  );
endinterface

// File: rtl/ng_cnt_sched.sv
// ---------------------------------------------------------------------------
// ng_cnt_sched
//   Priority-counter scheduler for the clock and time-pulse generator.
//   Accumulates increment requests for eight counter cells and, at each
//   entry into TP12, grants at most one cell to the control-pulse sequencer.
//
//   Cells: 0 TIME1, 1 TIME2, 2 TIME3, 3 TIME4, 4 TIME5, 5..7 external sources.
//
//   Ports
//     CLK1      in   CLK1 clock, all state changes on posedge
//     NPURST    in   asynchronous active-low master reset
//     TPG       in   current time-pulse state (4 bits)
//     F10X      in   100 Hz pulse, requests cells 0,2,3,4
//     OVF1      in   TIME1 overflow pulse, requests cell 1
//     EXT_REQ   in   external pulses, bit k requests cell 5+k
//     SCH_EN    in   1 = new grants allowed
//     sched     grant handshake (CNT_RQ / CNT_SEL out, CNT_ACK in)
//     PEND_ANY  out  some cell has a nonzero pending count (registered)
//     DROP      out  one-cycle pulse, a request was lost to saturation
//     DROP_ID   out  lowest cell index that lost a request
//
//   Configuration
//     CNT_SCHED_RR_EN  defined   : round-robin arbitration, search starts at
//                                  the cell after the last retired grant
//                      undefined : fixed priority, lowest index wins
// ---------------------------------------------------------------------------
module ng_cnt_sched #(
  parameter logic [3:0] TP12_CODE = 4'd13
) (
  input  logic             CLK1,
  input  logic             NPURST,
  input  logic [3:0]       TPG,
  input  logic             F10X,
  input  logic             OVF1,
  input  logic [2:0]       EXT_REQ,
  input  logic             SCH_EN,
  ng_cnt_sched_if.master   sched,
  output logic             PEND_ANY,
  output logic             DROP,
  output logic [2:0]       DROP_ID
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] pc_q [8];
  logic [1:0] pc_d [8];

  logic [7:0] req;
  logic [7:0] ret;
  logic [7:0] nz;
  logic [7:0] drop_vec;
  logic       retire;
  logic       tp12_d;
  logic       tp12_entry;
  logic [2:0] winner;
  logic       drop_d;
  logic [2:0] drop_id_d;
  logic       pend_d;

  // Request vector: F10X feeds TIME1/3/4/5, OVF1 feeds TIME2.
  assign req = {EXT_REQ, F10X, F10X, F10X, OVF1, F10X};

  assign retire     = (state_q == ST_GRANT) && sched.CNT_ACK;
  assign ret        = retire ? (8'b0000_0001 << sel_q) : '0;
  assign tp12_entry = (TPG == TP12_CODE) && !tp12_d;

  // -------------------------------------------------------------------------
  // Pending counters: request and retirement in the same cycle cancel out.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      nz[i]       = (pc_q[i] != 2'd0);
      drop_vec[i] = 1'b0;
      pc_d[i]     = pc_q[i];
      if (req[i] && !ret[i]) begin
        if (pc_q[i] == 2'd3) begin
          drop_vec[i] = 1'b1;
        end else begin
          pc_d[i] = pc_q[i] + 2'd1;
        end
      end else if (ret[i] && !req[i] && (pc_q[i] != 2'd0)) begin
        pc_d[i] = pc_q[i] - 2'd1;
      end
    end
  end

  always_comb begin
    drop_d    = |drop_vec;
    drop_id_d = '0;
    // Scan downward so the lowest dropping index is the last one written.
    for (int unsigned i = 8; i > 0; i--) begin
      if (drop_vec[i-1]) begin
        drop_id_d = 3'(i - 1);
      end
    end
  end

  always_comb begin
    pend_d = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pc_d[i] != 2'd0) begin
        pend_d = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration, evaluated on the pre-update pending counts.
  // -------------------------------------------------------------------------
`ifdef CNT_SCHED_RR_EN
  logic [2:0] rr_ptr;
  logic [2:0] rr_idx;
  logic       rr_found;

  // rr_ptr holds the first index to search, i.e. one past the last retired
  // grant; 3-bit addition gives the 7->0 wrap for free.
  always_comb begin
    winner   = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      rr_idx = rr_ptr + 3'(k);
      if (!rr_found && nz[rr_idx]) begin
        winner   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK1 or negedge NPURST) begin
    if (!NPURST) begin
      rr_ptr <= '0;
    end else if (retire) begin
      rr_ptr <= sel_q + 3'd1;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int unsigned k = 8; k > 0; k--) begin
      if (nz[k-1]) begin
        winner = 3'(k - 1);
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Grant FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (tp12_entry && SCH_EN && (|nz)) begin
          state_d = ST_GRANT;
          sel_d   = winner;
        end
      end
      ST_GRANT: begin
        if (sched.CNT_ACK) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK1 or negedge NPURST) begin
    if (!NPURST) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      tp12_d   <= 1'b0;
      PEND_ANY <= 1'b0;
      DROP     <= 1'b0;
      DROP_ID  <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        pc_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      tp12_d   <= (TPG == TP12_CODE);
      PEND_ANY <= pend_d;
      DROP     <= drop_d;
      DROP_ID  <= drop_id_d;
      for (int unsigned i = 0; i < 8; i++) begin
        pc_q[i] <= pc_d[i];
      end
    end
  end

  assign sched.CNT_RQ  = (state_q == ST_GRANT);
  assign sched.CNT_SEL = sel_q;

endmodule

// File: tb/tb_ng_cnt_sched.sv
module tb_ng_cnt_sched;

  logic       CLK1    = 1'b0;
  logic       NPURST  = 1'b0;
  logic [3:0] TPG     = 4'd0;
  logic       F10X    = 1'b0;
  logic       OVF1    = 1'b0;
  logic [2:0] EXT_REQ = 3'd0;
  logic       SCH_EN  = 1'b1;
  logic       PEND_ANY;
  logic       DROP;
  logic [2:0] DROP_ID;

  ng_cnt_sched_if bus ();

  ng_cnt_sched #(.TP12_CODE(4'd13)) dut (
    .CLK1     (CLK1),
    .NPURST   (NPURST),
    .TPG      (TPG),
    .F10X     (F10X),
    .OVF1     (OVF1),
    .EXT_REQ  (EXT_REQ),
    .SCH_EN   (SCH_EN),
    .sched    (bus),
    .PEND_ANY (PEND_ANY),
    .DROP     (DROP),
    .DROP_ID  (DROP_ID)
  );

  always #5 CLK1 = ~CLK1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_pc [8];
  bit m_rq, m_pend, m_drop, m_tp_prev;
  int m_sel, m_drop_id, m_ptr;

  function automatic bit cell_req(int i);
    if (i == 1) return OVF1;
    if (i <= 4) return F10X;
    return EXT_REQ[i-5];
  endfunction

  always @(posedge CLK1 or negedge NPURST) begin
    if (!NPURST) begin
      for (int i = 0; i < 8; i++) m_pc[i] = 0;
      m_rq = 0; m_sel = 0; m_pend = 0; m_drop = 0; m_drop_id = 0;
      m_tp_prev = 0; m_ptr = 0;
    end else begin
      bit entry, retire;
      int win, rcell, v;
      entry  = (TPG == 4'd13) && !m_tp_prev;
      retire = m_rq && bus.CNT_ACK;
      rcell  = m_sel;
      win = -1;
      for (int n = 0; n < 8; n++) begin
        v = (m_ptr + n) % 8;
        if (win < 0 && m_pc[v] > 0) win = v;
      end
      if (!m_rq) begin
        if (entry && SCH_EN && win >= 0) begin
          m_rq = 1; m_sel = win;
        end
      end else if (bus.CNT_ACK) begin
        m_rq = 0;
`ifdef CNT_SCHED_RR_EN
        m_ptr = (rcell + 1) % 8;
`endif
      end
      m_drop = 0; m_drop_id = 0;
      for (int i = 0; i < 8; i++) begin
        v = m_pc[i] + int'(cell_req(i)) - ((retire && rcell == i) ? 1 : 0);
        if (v > 3) begin
          v = 3;
          if (!m_drop) begin m_drop = 1; m_drop_id = i; end
        end
        if (v < 0) v = 0;
        m_pc[i] = v;
      end
      m_tp_prev = (TPG == 4'd13);
      m_pend = 0;
      for (int i = 0; i < 8; i++) if (m_pc[i] != 0) m_pend = 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLK1) begin
    check("cyc_CNT_RQ", int'(bus.CNT_RQ), int'(m_rq));
    check("cyc_CNT_SEL", int'(bus.CNT_SEL), m_sel);
    check("cyc_PEND_ANY", int'(PEND_ANY), int'(m_pend));
    check("cyc_DROP", int'(DROP), int'(m_drop));
    if (m_drop) check("cyc_DROP_ID", int'(DROP_ID), m_drop_id);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK1);
    #1;
    F10X = 1'b0; OVF1 = 1'b0; EXT_REQ = 3'd0; bus.CNT_ACK = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && PEND_ANY; k++) begin
      TPG = 4'd13; step();
      TPG = 4'd0; bus.CNT_ACK = 1'b1; step();
    end
    check("drain_done", int'(PEND_ANY), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_sel [3];
    int rr_exp;
    exp_sel = '{2, 3, 4};
    bus.CNT_ACK = 1'b0;
    repeat (3) @(posedge CLK1);
    #1 NPURST = 1'b1;
    check("rst_CNT_RQ", int'(bus.CNT_RQ), 0);
    check("rst_CNT_SEL", int'(bus.CNT_SEL), 0);
    check("rst_PEND_ANY", int'(PEND_ANY), 0);
    check("rst_DROP", int'(DROP), 0);
    check("rst_DROP_ID", int'(DROP_ID), 0);

    // F10X then four TP12 grants in priority order
    F10X = 1'b1; step();
    check("f10x_pend", int'(PEND_ANY), 1);
    TPG = 4'd13; step();
    check("g0_rq", int'(bus.CNT_RQ), 1);
    check("g0_sel", int'(bus.CNT_SEL), 0);
    TPG = 4'd0; bus.CNT_ACK = 1'b1; step();
    check("g0_ack_rq", int'(bus.CNT_RQ), 0);
    for (int g = 0; g < 3; g++) begin
      TPG = 4'd13; step();
      check("gN_rq", int'(bus.CNT_RQ), 1);
      check("gN_sel", int'(bus.CNT_SEL), exp_sel[g]);
      TPG = 4'd0; bus.CNT_ACK = 1'b1; step();
    end
    check("after4_pend", int'(PEND_ANY), 0);

    // Saturation on cell 6
    for (int p = 0; p < 4; p++) begin
      EXT_REQ = 3'b010; step();
    end
    check("sat_drop", int'(DROP), 1);
    check("sat_drop_id", int'(DROP_ID), 6);
    bus.CNT_ACK = 1'b1; step();   // ACK while idle is ignored
    check("sat_drop_clr", int'(DROP), 0);
    check("idle_ack_rq", int'(bus.CNT_RQ), 0);
    TPG = 4'd13; step();
    check("sat_grant_sel", int'(bus.CNT_SEL), 6);
    TPG = 4'd0; bus.CNT_ACK = 1'b1; step();
    drain();

    // Request coincident with retirement on cell 0
    F10X = 1'b1; step();
    TPG = 4'd13; step();
    check("coin_sel", int'(bus.CNT_SEL), 0);
    TPG = 4'd0; F10X = 1'b1; bus.CNT_ACK = 1'b1; step();
    check("coin_drop", int'(DROP), 0);
    check("coin_pend", int'(PEND_ANY), 1);
    TPG = 4'd13; step();
`ifdef CNT_SCHED_RR_EN
    rr_exp = 2;
`else
    rr_exp = 0;
`endif
    check("arb_mode_sel", int'(bus.CNT_SEL), rr_exp);
    TPG = 4'd0; bus.CNT_ACK = 1'b1; step();
    drain();

    // SCH_EN gating and TP12 hold
    EXT_REQ = 3'b001; step();
    EXT_REQ = 3'b001; step();
    SCH_EN = 1'b0; TPG = 4'd13; step();
    check("schen0_rq", int'(bus.CNT_RQ), 0);
    TPG = 4'd0; step();
    SCH_EN = 1'b1; TPG = 4'd13; step();
    check("schen1_rq", int'(bus.CNT_RQ), 1);
    check("schen1_sel", int'(bus.CNT_SEL), 5);
    bus.CNT_ACK = 1'b1; step();
    for (int h = 0; h < 3; h++) begin
      step();
      check("hold_rq", int'(bus.CNT_RQ), 0);
    end
    TPG = 4'd0; step();
    check("hold_pend", int'(PEND_ANY), 1);
    drain();

    // Reset during grant with PC5=2
    EXT_REQ = 3'b001; step();
    EXT_REQ = 3'b001; step();
    TPG = 4'd13; step();
    check("pre_rst_rq", int'(bus.CNT_RQ), 1);
    TPG = 4'd0;
    #2 NPURST = 1'b0;
    #1;
    check("async_rst_rq", int'(bus.CNT_RQ), 0);
    check("async_rst_pend", int'(PEND_ANY), 0);
    @(posedge CLK1);
    #1 NPURST = 1'b1;
    step();
    check("post_rst_rq", int'(bus.CNT_RQ), 0);
    check("post_rst_sel", int'(bus.CNT_SEL), 0);
    check("post_rst_pend", int'(PEND_ANY), 0);
    check("post_rst_drop", int'(DROP), 0);
    TPG = 4'd13; step();
    check("post_rst_nogrant", int'(bus.CNT_RQ), 0);
    TPG = 4'd0;
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
